// File: rtl/tally_pkg.sv
// -----------------------------------------------------------------------------
// tally_pkg
// Shared constants, the FSM state type and the checksum helper for the
// tally report transmitter.
//   TALLY_HEADER     first byte of every report frame
//   TALLY_NUM_BYTES  bytes per frame (header, four counts, checksum)
//   tally_state_t    UART sequencing states
//   tally_checksum   8-bit wrapping sum of the four counts
// -----------------------------------------------------------------------------
package tally_pkg;

    localparam logic [7:0] TALLY_HEADER    = 8'hA5;
    localparam int         TALLY_NUM_BYTES = 6;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        START_BIT = 2'd1,
        DATA_BIT  = 2'd2,
        STOP_BIT  = 2'd3
    } tally_state_t;

    // The checksum deliberately drops the carry so it always fits in one byte.
    function automatic logic [7:0] tally_checksum(input logic [7:0] a,
                                                  input logic [7:0] b,
                                                  input logic [7:0] c,
                                                  input logic [7:0] d);
        return a + b + c + d;
    endfunction

endpackage

// File: rtl/tally_uart_tx_byte.sv
// -----------------------------------------------------------------------------
// uart_tx_byte
// Serializes one byte as 8N1 (start bit, 8 data bits LSB first, stop bit).
// Ports:
//   clk    system clock
//   rst    synchronous active-high reset
//   load   accept 'data' this edge (honoured only while ready is high)
//   data   byte to send
//   tx     registered serial line, idle high
//   ready  high while idle and during the final cycle of a stop bit, so a
//          new byte loaded then follows the stop bit with no gap
// -----------------------------------------------------------------------------
module uart_tx_byte
    import tally_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] LAST_TICK = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] PRE_LAST  = TW'(CLKS_PER_BIT - 2);

    tally_state_t  state;
    logic [TW-1:0] timer;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;

    // Bit sequencing. The line value for the next bit is registered on the
    // edge that ends the current bit, so tx never has a combinational path.
    // ready is raised one cycle before the stop bit ends so the caller can
    // chain the next byte straight into a start bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            tx      <= 1'b1;
            ready   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        state <= START_BIT;
                        timer <= '0;
                        shreg <= data;
                        tx    <= 1'b0;
                        ready <= 1'b0;
                    end
                end
                START_BIT: begin
                    if (timer == LAST_TICK) begin
                        timer   <= '0;
                        bit_idx <= '0;
                        state   <= DATA_BIT;
                        tx      <= shreg[0];
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                DATA_BIT: begin
                    if (timer == LAST_TICK) begin
                        timer <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP_BIT;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[1];
                            shreg   <= {1'b0, shreg[7:1]};
                        end
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                STOP_BIT: begin
                    if (timer == LAST_TICK) begin
                        timer <= '0;
                        if (load) begin
                            state <= START_BIT;
                            shreg <= data;
                            tx    <= 1'b0;
                            ready <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        timer <= timer + 1'b1;
                        if (timer == PRE_LAST) begin
                            ready <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/tally_uart_tx.sv
// -----------------------------------------------------------------------------
// tally_uart_tx
// Sends the four candidate vote counters as one 6-byte UART report:
// A5, cand1..cand4, checksum. Counts are snapshotted when the request is
// accepted so live counting cannot tear the frame.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   mode                1 = results mode; requests are honoured only then
//   start               single-cycle report request
//   cand1..4_count      live vote counters
//   tx                  UART line (8N1, LSB first, idle high)
//   busy                high while a frame is in progress
//   done                one-cycle pulse after the final stop bit
// -----------------------------------------------------------------------------
module tally_uart_tx
    import tally_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode,
    input  logic       start,
    input  logic [7:0] cand1_count,
    input  logic [7:0] cand2_count,
    input  logic [7:0] cand3_count,
    input  logic [7:0] cand4_count,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] LAST_BYTE = 3'(TALLY_NUM_BYTES - 1);

    logic [7:0] snap1, snap2, snap3, snap4;
    logic [7:0] checksum;
    logic [2:0] byte_idx;
    logic       ser_ready;
    logic       ser_load;
    logic [7:0] ser_data;
    logic       accept;
    logic       advance;
    logic       finish;

    // The serializer's ready is only seen while busy in the last stop-bit
    // cycle, which is exactly when the next byte must be handed over.
    always_comb begin
        accept   = !busy && start && mode && ser_ready;
        advance  = busy && ser_ready && (byte_idx != LAST_BYTE);
        finish   = busy && ser_ready && (byte_idx == LAST_BYTE);
        ser_load = accept || advance;
    end

    // The header goes out on acceptance; afterwards the mux selects the byte
    // following the one currently on the line.
    always_comb begin
        ser_data = TALLY_HEADER;
        if (!accept) begin
            case (byte_idx)
                3'd0:    ser_data = snap1;
                3'd1:    ser_data = snap2;
                3'd2:    ser_data = snap3;
                3'd3:    ser_data = snap4;
                default: ser_data = checksum;
            endcase
        end
    end

    // Frame bookkeeping: snapshot and checksum on acceptance, byte index
    // advance on each chained byte, and the done pulse when the last stop
    // bit finishes.
    always_ff @(posedge clk) begin
        if (rst) begin
            snap1    <= '0;
            snap2    <= '0;
            snap3    <= '0;
            snap4    <= '0;
            checksum <= '0;
            byte_idx <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                snap1    <= cand1_count;
                snap2    <= cand2_count;
                snap3    <= cand3_count;
                snap4    <= cand4_count;
                checksum <= tally_checksum(cand1_count, cand2_count,
                                           cand3_count, cand4_count);
                byte_idx <= '0;
                busy     <= 1'b1;
            end else if (advance) begin
                byte_idx <= byte_idx + 3'd1;
            end else if (finish) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte (
        .clk  (clk),
        .rst  (rst),
        .load (ser_load),
        .data (ser_data),
        .tx   (tx),
        .ready(ser_ready)
    );

endmodule
